// File: rtl/ctrl_pkg.sv
// Shared definitions for the I2S_top register map and the APB sequencer.
package ctrl_pkg;

  localparam logic [31:0] CTRL_OFS = 32'h0;
  localparam logic [31:0] TXD_OFS  = 32'h4;
  localparam logic [31:0] RXD_OFS  = 32'h8;

  typedef enum logic [1:0] {
    MODE_MT = 2'b00,
    MODE_MR = 2'b01,
    MODE_ST = 2'b10,
    MODE_SR = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    WLEN_8  = 2'b00,
    WLEN_16 = 2'b01,
    WLEN_24 = 2'b10,
    WLEN_32 = 2'b11
  } wlen_t;

  // Control register layout of I2S_top, LSB last.
  typedef struct packed {
    logic [23:0] rsvd;
    logic        tranEn;
    mode_t       mode;
    logic        msbJust;
    wlen_t       wlen;
    logic        frame32;
    logic        stereo;
  } OP_t;

  localparam int TRAN_EN_BIT = 7;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    PRIME,
    ENABLE,
    RUN,
    DISABLE
  } seq_state_t;

  // Returns the control word with tran_en forced to the requested value.
  function automatic logic [31:0] ctrlWord(input logic [31:0] cfgWord, input logic en);
    logic [31:0] w;
    w = cfgWord;
    w[TRAN_EN_BIT] = en;
    return w;
  endfunction

endpackage

// File: rtl/i2s_apb_sequencer.sv
// APB master that configures one I2S_top, primes its TX FIFO, then
// round-robins the register port between TX writes and RX reads.
module i2s_apb_sequencer
  import ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          PRIME_WORDS = 4,
  parameter int          CNT_W       = 4
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] cfg,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        tx_space,
  input  logic        rx_avail,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  output logic        busy
);

  localparam logic [31:0]      ADDR_CTRL = BASE_ADDR + CTRL_OFS;
  localparam logic [31:0]      ADDR_TXD  = BASE_ADDR + TXD_OFS;
  localparam logic [31:0]      ADDR_RXD  = BASE_ADDR + RXD_OFS;
  localparam logic [CNT_W-1:0] PRIME_CNT = CNT_W'(PRIME_WORDS);

  seq_state_t       r_state, w_nextState;
  logic [31:0]      r_cfg;
  logic [CNT_W-1:0] r_cnt, w_cntNext;
  logic             r_lastWrite;
  logic             r_penable, r_pwrite, r_rxValid, r_busy;
  logic [31:0]      r_paddr, r_pwdata, r_rxData;
  logic             w_issue, w_write, w_txReady, w_readWins;
  logic             w_grantRead, w_grantWrite, w_writeReq;
  logic [31:0]      w_addr, w_wdata;

  // Next state and the single bus operation decided this cycle.
  always_comb begin
    w_nextState  = r_state;
    w_cntNext    = r_cnt;
    w_issue      = 1'b0;
    w_write      = 1'b0;
    w_addr       = '0;
    w_wdata      = '0;
    w_txReady    = 1'b0;
    w_readWins   = 1'b0;
    w_grantRead  = 1'b0;
    w_grantWrite = 1'b0;
    w_writeReq   = tx_valid && tx_space;
    case (r_state)
      IDLE: begin
        if (start) w_nextState = CFG;
      end
      CFG: begin
        w_issue     = 1'b1;
        w_write     = 1'b1;
        w_addr      = ADDR_CTRL;
        w_wdata     = ctrlWord(r_cfg, 1'b0);
        w_nextState = (PRIME_WORDS == 0) ? ENABLE : PRIME;
      end
      PRIME: begin
        if (stop) begin
          w_nextState = DISABLE;
        end else begin
          w_txReady = tx_space;
          if (w_writeReq) begin
            w_issue   = 1'b1;
            w_write   = 1'b1;
            w_addr    = ADDR_TXD;
            w_wdata   = tx_data;
            w_cntNext = r_cnt + 1'b1;
            if (w_cntNext == PRIME_CNT) w_nextState = ENABLE;
          end
        end
      end
      ENABLE: begin
        w_issue     = 1'b1;
        w_write     = 1'b1;
        w_addr      = ADDR_CTRL;
        w_wdata     = ctrlWord(r_cfg, 1'b1);
        w_nextState = RUN;
      end
      RUN: begin
        w_readWins = rx_avail && (!w_writeReq || r_lastWrite);
        w_txReady  = tx_space && !w_readWins && !stop;
        if (w_readWins) begin
          w_issue     = 1'b1;
          w_addr      = ADDR_RXD;
          w_grantRead = 1'b1;
        end else if (w_writeReq && !stop) begin
          w_issue      = 1'b1;
          w_write      = 1'b1;
          w_addr       = ADDR_TXD;
          w_wdata      = tx_data;
          w_grantWrite = 1'b1;
        end
        if (stop) w_nextState = DISABLE;
      end
      DISABLE: begin
        w_issue     = 1'b1;
        w_write     = 1'b1;
        w_addr      = ADDR_CTRL;
        w_wdata     = ctrlWord(r_cfg, 1'b0);
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State register, latched config, prime counter and last-grant bit.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_state     <= IDLE;
      r_cfg       <= '0;
      r_cnt       <= '0;
      r_lastWrite <= 1'b1;
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE && start) begin
        r_cfg <= cfg;
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cntNext;
      end
      if (w_grantRead)       r_lastWrite <= 1'b0;
      else if (w_grantWrite) r_lastWrite <= 1'b1;
    end
  end

  // Registered APB outputs: one single-cycle access per decided operation.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      r_penable <= w_issue;
      if (w_issue) begin
        r_pwrite <= w_write;
        r_paddr  <= w_addr;
        r_pwdata <= w_wdata;
      end
    end
  end

  // Capture read data at the edge ending a read access.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_rxValid <= 1'b0;
      r_rxData  <= '0;
    end else begin
      r_rxValid <= r_penable && !r_pwrite;
      if (r_penable && !r_pwrite) r_rxData <= prdata;
    end
  end

  // Busy stays up through the cycle carrying the final DISABLE write.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) r_busy <= 1'b0;
    else         r_busy <= (w_nextState != IDLE) || (r_state != IDLE);
  end

  assign tx_ready = w_txReady;
  assign rx_data  = r_rxData;
  assign rx_valid = r_rxValid;
  assign penable  = r_penable;
  assign pwrite   = r_pwrite;
  assign paddr    = r_paddr;
  assign pwdata   = r_pwdata;
  assign busy     = r_busy;

endmodule

// File: tb/tb_i2s_apb_sequencer.sv
// Scoreboard bench for i2s_apb_sequencer: stimulus queues expected bus
// transfers and RX words, monitors compare them when the DUT presents them.
module tb_i2s_apb_sequencer;

  localparam logic [31:0] CFG_IN   = 32'h0000_0097;
  localparam logic [31:0] CTRL_OFF = 32'h0000_0017;
  localparam logic [31:0] CTRL_ON  = 32'h0000_0097;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } busExp_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rxExp_t;

  logic        pclk = 1'b0;
  logic        preset;
  logic        start, stop, start2, stop2;
  logic        tx_valid, tx_space, rx_avail;
  logic [31:0] cfg, tx_data, prdata, prdata2;
  logic        tx_ready, rx_valid, penable, pwrite, busy;
  logic [31:0] rx_data, paddr, pwdata;
  logic        tx_ready2, rx_valid2, penable2, pwrite2, busy2;
  logic [31:0] rx_data2, paddr2, pwdata2;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int rdIdx = 0;
  int rdExp = 1;
  int wrIdx = 0;

  busExp_t busQ[$];
  busExp_t busQ2[$];
  rxExp_t  rxQ[$];
  rxExp_t  rxQ2[$];

  always #5 pclk = ~pclk;

  i2s_apb_sequencer dut (
    .pclk(pclk), .preset(preset), .start(start), .stop(stop), .cfg(cfg),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_space(tx_space), .rx_avail(rx_avail), .rx_data(rx_data),
    .rx_valid(rx_valid), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .busy(busy)
  );

  i2s_apb_sequencer #(.BASE_ADDR(32'h10), .PRIME_WORDS(0)) dut2 (
    .pclk(pclk), .preset(preset), .start(start2), .stop(stop2), .cfg(cfg),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready2),
    .tx_space(tx_space), .rx_avail(rx_avail), .rx_data(rx_data2),
    .rx_valid(rx_valid2), .penable(penable2), .pwrite(pwrite2), .paddr(paddr2),
    .pwdata(pwdata2), .prdata(prdata2), .busy(busy2)
  );

  // Simple slave model: each read returns the next word of a sequence.
  assign prdata  = 32'hA5A5_0001 + 32'(rdIdx);
  assign prdata2 = 32'hC3C3_0001;

  always @(posedge pclk) cycle <= cycle + 1;
  always @(posedge pclk) if (penable && !pwrite) rdIdx <= rdIdx + 1;

  task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic tv,
                               input logic ts, input logic ra, input logic [31:0] td);
    @(posedge pclk);
    #1;
    start    = st;
    stop     = sp;
    tx_valid = tv;
    tx_space = ts;
    rx_avail = ra;
    tx_data  = td;
  endtask

  task automatic pushBus(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    busQ.push_back('{wr, addr, data, cycle + 1});
  endtask

  task automatic pushBus2(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    busQ2.push_back('{wr, addr, data, cycle + 1});
  endtask

  task automatic pushRx(input logic [31:0] data);
    rxQ.push_back('{data, cycle + 2});
  endtask

  task automatic checkOutputsZero(input string tag);
    checkBit({tag, "_penable"}, penable, 1'b0);
    checkBit({tag, "_pwrite"}, pwrite, 1'b0);
    checkWord({tag, "_paddr"}, paddr, 32'h0);
    checkWord({tag, "_pwdata"}, pwdata, 32'h0);
    checkWord({tag, "_rx_data"}, rx_data, 32'h0);
    checkBit({tag, "_rx_valid"}, rx_valid, 1'b0);
    checkBit({tag, "_busy"}, busy, 1'b0);
    checkBit({tag, "_tx_ready"}, tx_ready, 1'b0);
  endtask

  // Monitor for the default instance.
  always @(negedge pclk) begin
    busExp_t e;
    rxExp_t  r;
    if (penable) begin
      if (busQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL bus_unexpected actual=wr%b@%h expected=no transfer", pwrite, paddr);
      end else begin
        e = busQ.pop_front();
        checkBit("bus_wr", pwrite, e.wr);
        checkWord("bus_addr", paddr, e.addr);
        if (e.wr) checkWord("bus_wdata", pwdata, e.data);
        checkWord("bus_cycle", 32'(cycle), 32'(e.cyc));
      end
    end
    if (rx_valid) begin
      if (rxQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL rx_unexpected actual=%h expected=no strobe", rx_data);
      end else begin
        r = rxQ.pop_front();
        checkWord("rx_data", rx_data, r.data);
        checkWord("rx_cycle", 32'(cycle), 32'(r.cyc));
      end
    end
  end

  // Monitor for the BASE_ADDR=0x10, PRIME_WORDS=0 instance.
  always @(negedge pclk) begin
    busExp_t e;
    rxExp_t  r;
    if (penable2) begin
      if (busQ2.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL bus2_unexpected actual=wr%b@%h expected=no transfer", pwrite2, paddr2);
      end else begin
        e = busQ2.pop_front();
        checkBit("bus2_wr", pwrite2, e.wr);
        checkWord("bus2_addr", paddr2, e.addr);
        if (e.wr) checkWord("bus2_wdata", pwdata2, e.data);
        checkWord("bus2_cycle", 32'(cycle), 32'(e.cyc));
      end
    end
    if (rx_valid2) begin
      if (rxQ2.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL rx2_unexpected actual=%h expected=no strobe", rx_data2);
      end else begin
        r = rxQ2.pop_front();
        checkWord("rx2_data", rx_data2, r.data);
        checkWord("rx2_cycle", 32'(cycle), 32'(r.cyc));
      end
    end
  end

  initial begin
    preset = 1'b0; start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
    tx_valid = 1'b0; tx_space = 1'b0; rx_avail = 1'b0; cfg = '0; tx_data = '0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    checkOutputsZero("reset");
    @(posedge pclk);
    #1 preset = 1'b1;

    // Session A: configure, prime four words, enable.
    cfg = CFG_IN;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hD000_0000);
    @(negedge pclk);
    checkBit("busy_start_cycle", busy, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hD000_0000);
    cfg = '0;
    pushBus(1'b1, 32'h0, CTRL_OFF);
    @(negedge pclk);
    checkBit("busy_rise", busy, 1'b1);
    checkBit("cfg_tx_ready", tx_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hD000_0000 + 32'(i));
      pushBus(1'b1, 32'h4, 32'hD000_0000 + 32'(i));
      @(negedge pclk);
      checkBit("prime_tx_ready", tx_ready, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    pushBus(1'b1, 32'h0, CTRL_ON);
    @(negedge pclk);
    checkBit("enable_tx_ready", tx_ready, 1'b0);

    // RUN with both read and write pending: read first, then alternate.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hE000_0000 + 32'(wrIdx));
      if ((i % 2) == 0) begin
        pushBus(1'b0, 32'h8, 32'h0);
        pushRx(32'hA5A5_0000 + 32'(rdExp));
        rdExp++;
        @(negedge pclk);
        checkBit("run_tx_ready_read", tx_ready, 1'b0);
      end else begin
        pushBus(1'b1, 32'h4, 32'hE000_0000 + 32'(wrIdx));
        wrIdx++;
        @(negedge pclk);
        checkBit("run_tx_ready_write", tx_ready, 1'b1);
      end
    end

    // Stop with a write pending: no write, then DISABLE.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hE000_0003);
    @(negedge pclk);
    checkBit("stop_tx_ready", tx_ready, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    pushBus(1'b1, 32'h0, CTRL_OFF);
    @(negedge pclk);
    checkBit("disable_busy", busy, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge pclk);
    checkBit("disable_bus_busy", busy, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge pclk);
    checkBit("busy_fall", busy, 1'b0);

    // Session B: restart, stall priming on tx_space, then stop with a read pending.
    cfg = CFG_IN;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hF000_0000);
    @(negedge pclk);
    checkBit("restart_cycle_busy", busy, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hF000_0000);
    cfg = '0;
    pushBus(1'b1, 32'h0, CTRL_OFF);
    @(negedge pclk);
    checkBit("restart_busy", busy, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hF000_0000);
      @(negedge pclk);
      checkBit("stall_tx_ready", tx_ready, 1'b0);
      if (i > 0) checkBit("stall_penable", penable, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hF000_0000 + 32'(i));
      pushBus(1'b1, 32'h4, 32'hF000_0000 + 32'(i));
      @(negedge pclk);
      checkBit("resume_tx_ready", tx_ready, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    pushBus(1'b1, 32'h0, CTRL_ON);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    pushBus(1'b0, 32'h8, 32'h0);
    pushRx(32'hA5A5_0000 + 32'(rdExp));
    rdExp++;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    pushBus(1'b1, 32'h0, CTRL_OFF);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge pclk);
    checkBit("sessionB_busy_fall", busy, 1'b0);

    // Session C: reset in the middle of priming.
    cfg = CFG_IN;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    pushBus(1'b1, 32'h0, CTRL_OFF);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hB000_0000);
    pushBus(1'b1, 32'h4, 32'hB000_0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge pclk);
    #1 preset = 1'b0;
    #1 checkOutputsZero("midreset");
    @(posedge pclk);
    #1 preset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0);
    @(negedge pclk);
    checkBit("post_reset_busy", busy, 1'b0);
    checkBit("post_reset_tx_ready", tx_ready, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge pclk);
    checkBit("post_reset_stop_ignored", busy, 1'b0);

    // Second instance: BASE_ADDR=0x10, no priming, one RX read.
    @(posedge pclk);
    #1 start2 = 1'b1; cfg = CFG_IN;
    @(posedge pclk);
    #1 start2 = 1'b0; cfg = '0;
    pushBus2(1'b1, 32'h10, CTRL_OFF);
    @(posedge pclk);
    #1 pushBus2(1'b1, 32'h10, CTRL_ON);
    @(posedge pclk);
    #1 rx_avail = 1'b1;
    pushBus2(1'b0, 32'h18, 32'h0);
    rxQ2.push_back('{32'hC3C3_0001, cycle + 2});
    @(posedge pclk);
    #1 rx_avail = 1'b0; stop2 = 1'b1;
    @(posedge pclk);
    #1 stop2 = 1'b0;
    pushBus2(1'b1, 32'h10, CTRL_OFF);
    repeat (4) @(posedge pclk);
    @(negedge pclk);
    checkBit("dut2_busy_fall", busy2, 1'b0);

    checkWord("busQ_drained", 32'(busQ.size()), 32'h0);
    checkWord("rxQ_drained", 32'(rxQ.size()), 32'h0);
    checkWord("busQ2_drained", 32'(busQ2.size()), 32'h0);
    checkWord("rxQ2_drained", 32'(rxQ2.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
